// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: state encoding, digit width
// and helpers that split a two-digit minute limit into BCD digits.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_PAUSE = 2'd2;

    function automatic logic [BCD_W-1:0] bcd_tens(input int unsigned v);
        return BCD_W'(v / 10);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_ones(input int unsigned v);
        return BCD_W'(v % 10);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Control inputs and display outputs of the stopwatch, bundled for the top level.
interface stopwatch_bcd_if;
    import stopwatch_pkg::*;

    logic             tick_in;
    logic             start_stop;
    logic             clear;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic             running;
    logic             wrap;

    modport master (
        output tick_in, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

    modport slave (
        input  tick_in, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with a programmable rollover value; carry is combinational
// so a whole chain of digits can ripple in a single clock.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [BCD_W-1:0] limit,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == limit) ? '0 : q + 1'b1;
        end
    end

    assign carry = inc & (q == limit);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch fed by the clock divider's square wave, with a
// start/stop/clear FSM, tick prescaler and a one-cycle wrap pulse.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | cleared, holds 00:00, waits for start
// S_RUN   | counting tick_in rising edges
// S_PAUSE | digits and prescaler frozen, ticks ignored
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int MAX_MIN  = 59
) (
    input logic            clk,
    input logic            reset,
    stopwatch_bcd_if.slave sw
);

    localparam int                PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [BCD_W-1:0]  MT_LIM    = bcd_tens(MAX_MIN);
    localparam logic [BCD_W-1:0]  MO_LAST   = bcd_ones(MAX_MIN);

    state_t            state_q;
    state_t            state_d;
    logic              running_c;
    logic              tick_d;
    logic              ss_d;
    logic              tick_rise;
    logic              ss_rise;
    logic              count_en;
    logic              sec_inc;
    logic [PCNT_W-1:0] pcnt;
    logic              wrap_q;

    logic [BCD_W-1:0]  so_q, st_q, mo_q, mt_q;
    logic              so_carry, st_carry, mo_carry, mt_carry;
    logic [BCD_W-1:0]  mo_limit;

    // Edge detectors start high so an input already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_d <= 1'b1;
            ss_d   <= 1'b1;
        end else begin
            tick_d <= sw.tick_in;
            ss_d   <= sw.start_stop;
        end
    end

    assign tick_rise = sw.tick_in & ~tick_d;
    assign ss_rise   = sw.start_stop & ~ss_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = S_IDLE;
        end else if (ss_rise) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running_c = (state_q == S_RUN);
    end

    // Counting follows the registered state, so a pause press still lets this cycle's tick in.
    assign count_en = running_c & tick_rise & ~sw.clear;
    assign sec_inc  = count_en & (pcnt == PCNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || sw.clear) begin
            pcnt <= '0;
        end else if (count_en) begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
        end
    end

    // In the last minute decade, minute units roll over at MAX_MIN's ones digit instead of 9.
    always_comb begin
        mo_limit = (mt_q == MT_LIM) ? MO_LAST : BCD_W'(9);
    end

    bcd_digit u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .inc   (sec_inc),
        .limit (BCD_W'(9)),
        .q     (so_q),
        .carry (so_carry)
    );

    bcd_digit u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .inc   (so_carry),
        .limit (BCD_W'(5)),
        .q     (st_q),
        .carry (st_carry)
    );

    bcd_digit u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .inc   (st_carry),
        .limit (mo_limit),
        .q     (mo_q),
        .carry (mo_carry)
    );

    bcd_digit u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .inc   (mo_carry),
        .limit (MT_LIM),
        .q     (mt_q),
        .carry (mt_carry)
    );

    // Top digit carrying out is exactly the MAX_MIN:59 -> 00:00 rollover.
    always_ff @(posedge clk) begin
        if (reset || sw.clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= mt_carry;
        end
    end

    assign sw.sec_ones = so_q;
    assign sw.sec_tens = st_q;
    assign sw.min_ones = mo_q;
    assign sw.min_tens = mt_q;
    assign sw.running  = running_c;
    assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (PRESCALE 1 and 4) share one stimulus
// stream and are compared against an elapsed-seconds reference model.
module tb_stopwatch_bcd;

    localparam int TOTAL = 60 * 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic tick;
    logic ss;
    logic clr;

    stopwatch_bcd_if sw1 ();
    stopwatch_bcd_if sw4 ();

    assign sw1.tick_in    = tick;
    assign sw1.start_stop = ss;
    assign sw1.clear      = clr;
    assign sw4.tick_in    = tick;
    assign sw4.start_stop = ss;
    assign sw4.clear      = clr;

    stopwatch_bcd #(.PRESCALE(1), .MAX_MIN(59)) dut1 (
        .clk   (clk),
        .reset (reset),
        .sw    (sw1)
    );

    stopwatch_bcd #(.PRESCALE(4), .MAX_MIN(59)) dut4 (
        .clk   (clk),
        .reset (reset),
        .sw    (sw4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 = PRESCALE 1, index 1 = PRESCALE 4.
    // m_mode: 0 stopped-and-cleared, 1 running, 2 paused.
    int m_secs [2];
    int m_pc   [2];
    int m_mode [2];
    bit m_wrap [2];
    bit m_prev_tick;
    bit m_prev_ss;

    function automatic int pre_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] exp_digits(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dig(input int k);
        if (k == 0) return {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones};
        return {sw4.min_tens, sw4.min_ones, sw4.sec_tens, sw4.sec_ones};
    endfunction

    function automatic logic run_of(input int k);
        return (k == 0) ? sw1.running : sw4.running;
    endfunction

    function automatic logic wrap_of(input int k);
        return (k == 0) ? sw1.wrap : sw4.wrap;
    endfunction

    task automatic step(input bit r, input bit t, input bit s, input bit c);
        bit tr;
        bit sr;
        reset = r;
        tick  = t;
        ss    = s;
        clr   = c;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_secs[k] = 0; m_pc[k] = 0; m_mode[k] = 0; m_wrap[k] = 1'b0;
            end
            m_prev_tick = 1'b1;
            m_prev_ss   = 1'b1;
        end else begin
            tr = t && !m_prev_tick;
            sr = s && !m_prev_ss;
            for (int k = 0; k < 2; k++) begin
                if (c) begin
                    m_secs[k] = 0; m_pc[k] = 0; m_mode[k] = 0; m_wrap[k] = 1'b0;
                end else begin
                    m_wrap[k] = 1'b0;
                    if (m_mode[k] == 1 && tr) begin
                        m_pc[k]++;
                        if (m_pc[k] == pre_of(k)) begin
                            m_pc[k] = 0;
                            m_secs[k]++;
                            if (m_secs[k] == TOTAL) begin
                                m_secs[k] = 0;
                                m_wrap[k] = 1'b1;
                            end
                        end
                    end
                    if (sr) m_mode[k] = (m_mode[k] == 1) ? 2 : 1;
                end
            end
            m_prev_tick = t;
            m_prev_ss   = s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        step(1'b0, 1'b1, ss, 1'b0);
        step(1'b0, 1'b0, ss, 1'b0);
    endtask

    task automatic press_ss();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({dig(0), run_of(0), wrap_of(0)} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_release got %h/%b/%b want 0000/0/0", dig(0), run_of(0), wrap_of(0));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ({dig(k), run_of(k), wrap_of(k)} !== 18'h0) begin
                    n_bad++;
                    $display("FAIL reset_idle[%0d] got %h/%b/%b want 0000/0/0", k, dig(k), run_of(k), wrap_of(k));
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_count_61();
        press_ss();
        for (int i = 0; i < 61; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig(k) !== exp_digits(m_secs[k])) begin
                    n_bad++;
                    $display("FAIL count61_edge[%0d] i=%0d got %h want %h", k, i, dig(k), exp_digits(m_secs[k]));
                end
            end
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (dig(0) !== 16'h0101 || run_of(0) !== 1'b1) begin
            n_bad++;
            $display("FAIL count61_final got %h run=%b want 0101 run=1", dig(0), run_of(0));
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (m_secs[0] != TOTAL - 1 && guard < 4000) begin
            tick_pulse();
            guard++;
        end
        n_cmp++;
        if (dig(0) !== 16'h5959 || wrap_of(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_pre got %h wrap=%b want 5959 wrap=0", dig(0), wrap_of(0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dig(0) !== 16'h0000 || wrap_of(0) !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_edge got %h wrap=%b want 0000 wrap=1", dig(0), wrap_of(0));
        end
        n_cmp++;
        if (dig(1) !== exp_digits(m_secs[1]) || wrap_of(1) !== m_wrap[1]) begin
            n_bad++;
            $display("FAIL wrap_pre4 got %h wrap=%b want %h wrap=%b", dig(1), wrap_of(1), exp_digits(m_secs[1]), m_wrap[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dig(0) !== 16'h0000 || wrap_of(0) !== 1'b0 || run_of(0) !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_after got %h wrap=%b run=%b want 0000 wrap=0 run=1", dig(0), wrap_of(0), run_of(0));
        end
    endtask

    task automatic test_pause();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        press_ss();
        for (int i = 0; i < 7; i++) tick_pulse();
        press_ss();
        n_cmp++;
        if (dig(0) !== 16'h0007 || run_of(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_enter got %h run=%b want 0007 run=0", dig(0), run_of(0));
        end
        for (int i = 0; i < 5; i++) tick_pulse();
        n_cmp++;
        if (dig(0) !== 16'h0007) begin
            n_bad++;
            $display("FAIL pause_hold got %h want 0007", dig(0));
        end
        press_ss();
        n_cmp++;
        if (dig(0) !== 16'h0007 || run_of(0) !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_resume got %h run=%b want 0007 run=1", dig(0), run_of(0));
        end
        tick_pulse();
        n_cmp++;
        if (dig(0) !== 16'h0008) begin
            n_bad++;
            $display("FAIL pause_next got %h want 0008", dig(0));
        end
    endtask

    task automatic test_ss_tick_same();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (dig(0) !== 16'h0009 || run_of(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL ss_tick_same got %h run=%b want 0009 run=0", dig(0), run_of(0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear_tick();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        press_ss();
        for (int i = 0; i < 754; i++) tick_pulse();
        n_cmp++;
        if (dig(0) !== 16'h1234) begin
            n_bad++;
            $display("FAIL clear_pre got %h want 1234", dig(0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (dig(0) !== 16'h0000 || wrap_of(0) !== 1'b0 || run_of(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_tick got %h wrap=%b run=%b want 0000 wrap=0 run=0", dig(0), wrap_of(0), run_of(0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_pulse();
        n_cmp++;
        if (dig(0) !== 16'h0000 || run_of(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_idle got %h run=%b want 0000 run=0", dig(0), run_of(0));
        end
    endtask

    task automatic test_prescale();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        press_ss();
        for (int i = 0; i < 8; i++) tick_pulse();
        n_cmp++;
        if (dig(1) !== 16'h0002) begin
            n_bad++;
            $display("FAIL prescale_8 got %h want 0002", dig(1));
        end
        for (int i = 0; i < 3; i++) tick_pulse();
        press_ss();
        for (int i = 0; i < 2; i++) tick_pulse();
        press_ss();
        n_cmp++;
        if (dig(1) !== 16'h0002) begin
            n_bad++;
            $display("FAIL prescale_hold got %h want 0002", dig(1));
        end
        tick_pulse();
        n_cmp++;
        if (dig(1) !== 16'h0003) begin
            n_bad++;
            $display("FAIL prescale_resume got %h want 0003", dig(1));
        end
    endtask

    task automatic test_random();
        bit t;
        bit s;
        bit c;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            t = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) s = ~s;
            c = ($urandom_range(0, 299) == 0);
            step(1'b0, t, s, c);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig(k) !== exp_digits(m_secs[k]) || run_of(k) !== (m_mode[k] == 1) || wrap_of(k) !== m_wrap[k]) begin
                    n_bad++;
                    $display("FAIL random[%0d] cyc=%0d got %h/%b/%b want %h/%b/%b", k, i, dig(k), run_of(k), wrap_of(k),
                             exp_digits(m_secs[k]), (m_mode[k] == 1), m_wrap[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_61();
        test_wrap();
        test_pause();
        test_ss_tick_same();
        test_clear_tick();
        test_prescale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
